y_rr_mux: RTL and testbench
===========================

// Module: y_rr_mux
// PURPOSE
//   Registered N-channel, W-bit arbitrating multiplexer; parametrised successor of the 1-bit 2:1 mux.
//   Picks one valid input channel per cycle (round-robin or fixed priority) and registers its data.
//   Uses a valid/ready handshake on every input channel and on the single output.
//   Sits between multiple producers (e.g. fetch/writeback sources) and one shared consumer/bus.
// PARAMETERS
//   W     8   data width per channel (>=1)
//   N     4   number of input channels (>=1, need not be a power of two)
//   MODE  0   0 = round-robin arbitration; 1 = fixed priority, lowest index wins
//   CW    derived = (N>1) ? $clog2(N) : 1; width of channel index (localparam)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   N      per-channel request; bit i = channel i
//   in_data    in   N*W    packed data; channel i at in_data[i*W +: W]
//   in_ready   out  N      one-hot (or zero) accept; channel i transfers when in_valid[i]&in_ready[i]
//   out_valid  out  1      out_data/out_chan hold a valid item
//   out_data   out  W      registered data of the granted channel
//   out_chan   out  CW     index of the channel that supplied out_data
//   out_ready  in   1      consumer accepts when out_valid&out_ready
// BEHAVIOUR
//   - Reset (sync, wins over everything): out_valid=0, out_data=0, out_chan=0, ptr=0; in_ready=0 while reset=1.
//   - load = ~out_valid | out_ready (output register empty or being drained this cycle).
//   - Grant (combinational): MODE 0: first i with in_valid[i] scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//     MODE 1: lowest i with in_valid[i]; ptr unused (held at 0).
//   - in_ready = onehot(grant) & {N{load & ~reset}}; zero when no channel valid.
//     in_ready depends combinationally on out_ready (no skid buffer); documented, intended.
//   - Posedge, load=1, some in_valid: out_valid<=1, out_data<=in_data[g], out_chan<=g;
//     MODE 0: ptr <= (g==N-1) ? 0 : g+1 (wrap, correct for non-power-of-two N).
//   - Posedge, load=1, no in_valid: out_valid<=0; out_data, out_chan, ptr hold.
//   - Posedge, load=0 (out_valid&~out_ready): all state holds; out_data/out_chan stable.
//   - Latency: input accept -> out_valid in next cycle (1 cycle). Throughput 1 item/cycle at out_ready=1.
//   - Simultaneous drain+fill: consumer takes the old item and the new one loads on the same edge; no bubble.
//   - Upstream must hold in_valid/in_data until accepted; block does not check this.
//   - No item lost or duplicated: each accepted input appears exactly once on the output.
//   - Reset mid-transfer: held output item is discarded; no in_ready during reset.
//   - N=1: out_chan always 0; behaves as a 1-deep registered pipe stage.
// TESTING (W=8, N=4 unless noted; scoreboard compares out_data/out_chan against expected with ===)
//   1. reset=1 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=8'h00, out_chan=0, in_ready=4'b0000.
//   2. MODE 0, in_valid=4'b1111 held, data ch0..3=A0..A3, out_ready=1 -> out_chan 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0.
//   3. Only ch2 valid (8'h5C), out_ready=0 for 3 cycles -> out_valid=1, out_data=8'h5C, out_chan=2 held, in_ready=0;
//      out_ready=1 -> item drained and next ch2 item loads on the same edge.
//   4. MODE 0, ptr=3 after a ch2 grant, only ch0 valid -> ch0 granted (wrap), ptr becomes 1; N=3 run wraps 2->0.
//   5. MODE 1, in_valid=4'b1111 -> out_chan=0 every cycle; drop ch0 -> out_chan=1; drop ch1 -> out_chan=2.
//   6. Reset with out_valid=1, out_ready=0 -> next cycle out_valid=0, out_data=8'h00, ptr=0; next grant from ch0.

Source files
------------

// File: rtl/y_rr_mux.sv
// y_rr_mux: registered N-channel, W-bit arbitrating multiplexer.
// Each cycle one valid input channel is granted (round-robin or fixed
// priority) and its data is captured into a single output register with a
// valid/ready handshake. in_ready is combinational on out_ready, so there is
// no skid buffer: a channel is accepted only while the output register is
// empty or being drained on the same edge.
module y_rr_mux #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int MODE = 0,
    localparam int CW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [CW-1:0]    out_chan,
    input  logic             out_ready
);

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [CW-1:0] out_chan_q,  out_chan_d;
    logic [CW-1:0] ptr_q,       ptr_d;

    logic          any_valid;
    logic [CW-1:0] grant;
    logic          load;
    logic [W-1:0]  ch_data [N];

    // Output register may take a new item when empty or drained this cycle.
    assign load = ~out_valid_q | out_ready;

    // Unpack the flat data bus into per-channel words.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            ch_data[k] = in_data[k*W +: W];
        end
    end

    // Arbiter: scan from ptr with wrap (round-robin) or from 0 (fixed priority).
    always_comb begin
        int            idx;
        logic [CW-1:0] idx_c;
        any_valid = 1'b0;
        grant     = '0;
        idx       = 0;
        idx_c     = '0;
        for (int k = 0; k < N; k++) begin
            if (MODE == 0) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
            end else begin
                idx = k;
            end
            idx_c = CW'(idx);
            if (!any_valid && in_valid[idx_c]) begin
                any_valid = 1'b1;
                grant     = idx_c;
            end
        end
    end

    // One-hot accept for the granted channel, suppressed during reset or stall.
    always_comb begin
        in_ready = '0;
        if (any_valid && load && !reset) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Next-state: load the granted item, or go empty when nothing is offered.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = any_valid;
            if (any_valid) begin
                out_data_d = ch_data[grant];
                out_chan_d = grant;
                if (MODE == 0) begin
                    if (grant == CW'(N - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant + CW'(1);
                    end
                end
            end
        end
    end

    // State registers with synchronous reset that discards any held item.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_y_rr_mux.sv
// Testbench for y_rr_mux: three instances (round-robin N=4, fixed priority
// N=4, round-robin N=3) driven by randomized producers and consumers. A
// transaction-level model predicts each accepted item and pushes it into a
// per-instance queue; a negedge monitor compares presented outputs against
// the queue head and pops on each output transfer.
module tb_y_rr_mux;

    localparam int MODEV [3] = '{0, 1, 0};
    localparam int NV    [3] = '{4, 4, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [3:0]  iv   [3];
    logic [31:0] id   [3];
    logic        ordy [3];

    logic [3:0] ir0, ir1;
    logic [2:0] ir2;
    logic       ov0, ov1, ov2;
    logic [7:0] od0, od1, od2;
    logic [1:0] oc0, oc1, oc2;

    y_rr_mux #(.W(8), .N(4), .MODE(0)) u_rr4 (
        .clk(clk), .reset(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_chan(oc0), .out_ready(ordy[0]));
    y_rr_mux #(.W(8), .N(4), .MODE(1)) u_fp4 (
        .clk(clk), .reset(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_chan(oc1), .out_ready(ordy[1]));
    y_rr_mux #(.W(8), .N(3), .MODE(0)) u_rr3 (
        .clk(clk), .reset(rst), .in_valid(iv[2][2:0]), .in_data(id[2][23:0]), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_chan(oc2), .out_ready(ordy[2]));

    int errors = 0;
    int checks = 0;

    // Expected {chan, data} per instance.
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] q2 [$];

    // Reference model state: output-occupied flag, rotation start, producer holdings.
    bit         mfull [3];
    int         mptr  [3];
    bit   [3:0] pend  [3];
    logic [7:0] pdat  [3][4];

    function automatic logic [3:0] get_ir(int k);
        if (k == 0) return ir0;
        if (k == 1) return ir1;
        return {1'b0, ir2};
    endfunction
    function automatic logic get_ov(int k);
        if (k == 0) return ov0;
        if (k == 1) return ov1;
        return ov2;
    endfunction
    function automatic logic [9:0] get_out(int k);
        if (k == 0) return {oc0, od0};
        if (k == 1) return {oc1, od1};
        return {oc2, od2};
    endfunction
    function automatic int qsize(int k);
        if (k == 0) return q0.size();
        if (k == 1) return q1.size();
        return q2.size();
    endfunction
    function automatic logic [9:0] qfront(int k);
        if (k == 0) return q0[0];
        if (k == 1) return q1[0];
        return q2[0];
    endfunction
    task automatic qpush(int k, logic [9:0] v);
        if (k == 0) q0.push_back(v);
        else if (k == 1) q1.push_back(v);
        else q2.push_back(v);
    endtask
    task automatic qpop(int k);
        logic [9:0] t;
        if (k == 0) t = q0.pop_front();
        else if (k == 1) t = q1.pop_front();
        else t = q2.pop_front();
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare presented items to the queue head; pop on transfer.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (get_ov(k)) begin
                    if (qsize(k) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out%0d_unexpected: got item %0h expected none", k, get_out(k));
                    end else begin
                        check($sformatf("out%0d_item", k), 32'(get_out(k)), 32'(qfront(k)));
                        if (ordy[k]) qpop(k);
                    end
                end
            end
        end
    end

    // One bus cycle: mask = channels allowed to start new items, pv/pr = percent odds.
    task automatic cycle(input logic [3:0] mask, input int pv, input int pr, input bit do_rst);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out%0d_valid", k), 32'(get_ov(k)), 32'(mfull[k]));
            if (rst) check($sformatf("out%0d_reset_item", k), 32'(get_out(k)), 32'd0);
        end
        rst = do_rst;
        if (do_rst) begin
            q0.delete(); q1.delete(); q2.delete();
            for (int k = 0; k < 3; k++) begin
                mfull[k] = 1'b0;
                mptr[k]  = 0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < NV[k]; ch++) begin
                if (!pend[k][ch] && mask[ch] && $urandom_range(99) < pv) begin
                    pend[k][ch] = 1'b1;
                    pdat[k][ch] = 8'($urandom);
                end
            end
            for (int ch = 0; ch < 4; ch++) begin
                iv[k][ch]        = pend[k][ch];
                id[k][ch*8 +: 8] = pend[k][ch] ? pdat[k][ch] : 8'($urandom);
            end
            ordy[k] = do_rst ? 1'b0 : ($urandom_range(99) < pr);
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            int         g;
            bit         ld;
            logic [3:0] e;
            g  = -1;
            for (int j = 0; j < NV[k]; j++) begin
                int c;
                c = (MODEV[k] == 0) ? (mptr[k] + j) % NV[k] : j;
                if (g < 0 && pend[k][c]) g = c;
            end
            ld = !mfull[k] || ordy[k];
            e  = (g >= 0 && ld && !do_rst) ? 4'(1 << g) : 4'd0;
            check($sformatf("in%0d_ready", k), 32'(get_ir(k)), 32'(e));
            if (!do_rst && ld) begin
                if (g >= 0) begin
                    qpush(k, {2'(g), pdat[k][g]});
                    pend[k][g] = 1'b0;
                    mfull[k]   = 1'b1;
                    if (MODEV[k] == 0) mptr[k] = (g + 1) % NV[k];
                end else begin
                    mfull[k] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = '0; id[k] = '0; ordy[k] = 1'b0;
            mfull[k] = 1'b0; mptr[k] = 0; pend[k] = '0;
        end
        // Reset with every channel requesting
        repeat (2) cycle(4'b1111, 100, 100, 1'b1);
        // Round-robin across all channels at full throughput
        repeat (12) cycle(4'b1111, 100, 100, 1'b0);
        repeat (8) cycle(4'b0000, 0, 100, 1'b0);
        // Single channel with output stall, then drain+fill
        repeat (4) cycle(4'b0100, 100, 0, 1'b0);
        repeat (3) cycle(4'b0100, 100, 100, 1'b0);
        repeat (8) cycle(4'b0000, 0, 100, 1'b0);
        // Pointer wrap after a ch2 grant
        cycle(4'b0100, 100, 100, 1'b0);
        repeat (3) cycle(4'b0001, 100, 100, 1'b0);
        repeat (8) cycle(4'b0000, 0, 100, 1'b0);
        // Priority changes as low channels drop out
        repeat (6) cycle(4'b1111, 100, 100, 1'b0);
        repeat (6) cycle(4'b1110, 100, 100, 1'b0);
        repeat (6) cycle(4'b1100, 100, 100, 1'b0);
        repeat (8) cycle(4'b0000, 0, 100, 1'b0);
        // Reset while an item is held under stall
        repeat (3) cycle(4'b1111, 100, 0, 1'b0);
        repeat (2) cycle(4'b1111, 100, 0, 1'b1);
        repeat (6) cycle(4'b1111, 100, 100, 1'b0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom), $urandom_range(100), $urandom_range(20, 100), 1'b0);
        end
        repeat (12) cycle(4'b0000, 0, 100, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("q%0d_leftover", k), 32'(qsize(k)), 32'd0);
            check($sformatf("p%0d_leftover", k), 32'(pend[k]), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
